// File: rtl/uvmt_cv32e40x_obi_rchk_pkg.sv
// rtl/uvmt_cv32e40x_obi_rchk_pkg.sv - PMA region type and default attributes for the rchk tracker
package uvmt_cv32e40x_obi_rchk_pkg;

  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
    logic        integrity;
  } pma_cfg_t;

  // Unmatched address with regions configured: I/O-like, no integrity
  localparam pma_cfg_t PMA_R_DEFAULT = '{word_addr_low:  32'h0,
                                         word_addr_high: 32'h0,
                                         main:           1'b0,
                                         bufferable:     1'b0,
                                         cacheable:      1'b0,
                                         integrity:      1'b0};

  // No PMA configured at all: everything is main memory without integrity
  localparam pma_cfg_t NO_PMA_R_DEFAULT = '{word_addr_low:  32'h0,
                                            word_addr_high: 32'h0,
                                            main:           1'b1,
                                            bufferable:     1'b0,
                                            cacheable:      1'b0,
                                            integrity:      1'b0};

endpackage

// File: rtl/uvmt_cv32e40x_obi_rchk_tracker.sv
// rtl/uvmt_cv32e40x_obi_rchk_tracker.sv - OBI response-integrity shim: tracks per-request integrity and drives rchk
module uvmt_cv32e40x_obi_rchk_tracker
  import uvmt_cv32e40x_obi_rchk_pkg::*;
#(
  parameter int       DATA_WIDTH      = 32,
  parameter int       CHK_WIDTH       = DATA_WIDTH/8+1,
  parameter int       MAX_OUTSTANDING = 2,
  parameter int       PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default:PMA_R_DEFAULT},
  parameter logic [31:0] DM_REGION_START = 32'hF0000000,
  parameter logic [31:0] DM_REGION_END   = 32'hF0003FFF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_i,
  input  logic                                 gnt_i,
  input  logic                                 dbg_i,
  input  logic [31:0]                          addr_i,
  input  logic [DATA_WIDTH-1:0]                rdata_i,
  input  logic                                 rvalid_i,
  input  logic                                 err_i,
  input  logic [CHK_WIDTH-1:0]                 rchk_i,
  input  logic [1:0]                           mode_i,
  input  logic [7:0]                           inj_period_i,
  input  logic [$clog2(CHK_WIDTH)-1:0]         inj_bit_i,
  output logic [CHK_WIDTH-1:0]                 rchk_o,
  output logic                                 resp_integrity_o,
  output logic                                 inj_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 proto_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int NBYTE = DATA_WIDTH/8;

  localparam logic [1:0] MODE_GEN    = 2'b01;
  localparam logic [1:0] MODE_INJECT = 2'b10;

  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [7:0]                 inj_cnt_q;

  logic [31:0]          word_addr;
  logic                 pma_integ;
  logic                 req_integ;
  logic                 pma_found;
  logic                 push, empty, full;
  logic                 pop_ok, pop_err, push_ok, push_err;
  logic                 inj_adv;
  logic [CHK_WIDTH-1:0] gen_chk, base_chk, inj_mask;

  assign word_addr = {2'b00, addr_i[31:2]};

  // Lowest-index matching region wins
  always_comb begin
    pma_found = 1'b0;
    pma_integ = PMA_R_DEFAULT.integrity;
    if (PMA_NUM_REGIONS == 0) begin
      pma_integ = NO_PMA_R_DEFAULT.integrity;
    end else begin
      for (int i = 0; i < PMA_NUM_REGIONS; i++) begin
        if (!pma_found && (word_addr >= PMA_CFG[i].word_addr_low) &&
            (word_addr < PMA_CFG[i].word_addr_high)) begin
          pma_found = 1'b1;
          pma_integ = PMA_CFG[i].integrity;
        end
      end
    end
  end

  assign req_integ = (dbg_i && (addr_i >= DM_REGION_START) && (addr_i <= DM_REGION_END))
                     ? 1'b0 : pma_integ;

  assign push     = req_i && gnt_i;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign pop_ok   = rvalid_i && !empty;
  assign pop_err  = rvalid_i && empty;
  // A pop in the same cycle frees the slot the full-FIFO push needs
  assign push_ok  = push && (!full || pop_ok);
  assign push_err = push && full && !pop_ok;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign resp_integrity_o = empty ? 1'b0 : fifo_q[rd_ptr_q];
  assign outstanding_o    = count_q;

  always_comb begin
    gen_chk = '0;
    for (int k = 0; k < NBYTE; k++) begin
      gen_chk[k] = ^rdata_i[8*k +: 8];
    end
    gen_chk[CHK_WIDTH-1] = err_i;
  end

  assign inj_adv = rvalid_i && resp_integrity_o && (mode_i == MODE_INJECT) && (inj_period_i != 8'd0);
  // >= rather than == so a period lowered mid-run fires immediately instead of wrapping
  assign inj_o   = inj_adv && (inj_cnt_q >= (inj_period_i - 8'd1));

  always_comb begin
    inj_mask = '0;
    for (int k = 0; k < CHK_WIDTH; k++) begin
      inj_mask[k] = inj_o && (int'(inj_bit_i) == k);
    end
  end

  always_comb begin
    base_chk = rchk_i;
    if ((mode_i == MODE_GEN) || (mode_i == MODE_INJECT)) begin
      base_chk = gen_chk;
    end
    rchk_o = (resp_integrity_o ? base_chk : ~base_chk) ^ inj_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inj_cnt_q   <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= req_integ;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (inj_adv) begin
        inj_cnt_q <= inj_o ? 8'd0 : inj_cnt_q + 8'd1;
      end
      proto_err_o <= push_err || pop_err;
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_obi_rchk_tracker.sv
// tb/tb_uvmt_cv32e40x_obi_rchk_tracker.sv - directed self-checking bench for the OBI rchk tracker
module tb_uvmt_cv32e40x_obi_rchk_tracker;
  import uvmt_cv32e40x_obi_rchk_pkg::*;

  localparam int DW = 32;
  localparam int CW = DW/8+1;
  localparam int MO = 3;

  // Region 0: bytes 0x1000..0x1FFF; region 1: debug-module window; both with integrity
  localparam pma_cfg_t R0 = '{word_addr_low: 32'h0000_0400, word_addr_high: 32'h0000_0800,
                              main: 1'b1, bufferable: 1'b0, cacheable: 1'b0, integrity: 1'b1};
  localparam pma_cfg_t R1 = '{word_addr_low: 32'h3C00_0000, word_addr_high: 32'h3C00_1000,
                              main: 1'b1, bufferable: 1'b0, cacheable: 1'b0, integrity: 1'b1};
  localparam pma_cfg_t CFG[1:0] = '{R1, R0};

  localparam logic [31:0] A_INT = 32'h0000_1000;
  localparam logic [31:0] A_NON = 32'h0000_2000;

  logic          clk, rst_n;
  logic          req, gnt, dbg, rvalid, err;
  logic [31:0]   addr;
  logic [DW-1:0] rdata;
  logic [CW-1:0] rchk_in;
  logic [1:0]    mode;
  logic [7:0]    inj_period;
  logic [2:0]    inj_bit;
  logic [CW-1:0] rchk_out;
  logic          resp_integ, inj, proto_err;
  logic [1:0]    outstanding;

  int tests_run = 0;
  int tests_failed = 0;

  uvmt_cv32e40x_obi_rchk_tracker #(
    .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .PMA_NUM_REGIONS(2), .PMA_CFG(CFG),
    .DM_REGION_START(32'hF000_0000), .DM_REGION_END(32'hF000_3FFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_i(gnt), .dbg_i(dbg), .addr_i(addr),
    .rdata_i(rdata), .rvalid_i(rvalid), .err_i(err), .rchk_i(rchk_in), .mode_i(mode),
    .inj_period_i(inj_period), .inj_bit_i(inj_bit), .rchk_o(rchk_out),
    .resp_integrity_o(resp_integ), .inj_o(inj), .outstanding_o(outstanding),
    .proto_err_o(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic [31:0] a, input logic d);
    req = 1'b1; gnt = 1'b1; addr = a; dbg = d;
    tick();
    req = 1'b0; gnt = 1'b0; dbg = 1'b0;
  endtask

  task automatic resp(input logic [31:0] d, input logic e, input logic [4:0] rc,
                      output logic [4:0] o_rchk, output logic o_integ, output logic o_inj);
    rdata = d; err = e; rchk_in = rc; rvalid = 1'b1;
    #1;
    o_rchk = rchk_out; o_integ = resp_integ; o_inj = inj;
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (outstanding !== 2'd0) begin
      tests_failed++; $display("FAIL reset_outstanding got %0d exp 0", outstanding);
    end
    tests_run++;
    if (proto_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_proto_err got %b exp 0", proto_err);
    end
    tests_run++;
    if (resp_integ !== 1'b0) begin
      tests_failed++; $display("FAIL reset_integ got %b exp 0", resp_integ);
    end
  endtask

  task automatic test_gen_pass();
    logic [4:0] r; logic ig, ij;
    mode = 2'b01;
    grant(A_INT, 1'b0);
    tests_run++;
    if (outstanding !== 2'd1) begin
      tests_failed++; $display("FAIL gen_outstanding got %0d exp 1", outstanding);
    end
    resp(32'h0000_0001, 1'b0, 5'b00000, r, ig, ij);
    tests_run++;
    if (r !== 5'b00001 || ig !== 1'b1) begin
      tests_failed++; $display("FAIL gen_integ rchk %b integ %b exp 00001 1", r, ig);
    end
    grant(A_NON, 1'b0);
    resp(32'h0000_0001, 1'b0, 5'b00000, r, ig, ij);
    tests_run++;
    if (r !== 5'b11110 || ig !== 1'b0) begin
      tests_failed++; $display("FAIL gen_nonint rchk %b integ %b exp 11110 0", r, ig);
    end
    grant(A_INT, 1'b0);
    resp(32'hFF01_0380, 1'b1, 5'b00000, r, ig, ij);
    tests_run++;
    if (r !== 5'b10101) begin
      tests_failed++; $display("FAIL gen_bytes rchk %b exp 10101", r);
    end
    mode = 2'b00;
    grant(A_NON, 1'b0);
    resp(32'h0000_0001, 1'b0, 5'b10101, r, ig, ij);
    tests_run++;
    if (r !== 5'b01010) begin
      tests_failed++; $display("FAIL pass_nonint rchk %b exp 01010", r);
    end
    mode = 2'b11;
    grant(A_INT, 1'b0);
    resp(32'h0000_0001, 1'b0, 5'b10101, r, ig, ij);
    tests_run++;
    if (r !== 5'b10101) begin
      tests_failed++; $display("FAIL pass_mode3 rchk %b exp 10101", r);
    end
    tests_run++;
    if (outstanding !== 2'd0) begin
      tests_failed++; $display("FAIL gen_drain got %0d exp 0", outstanding);
    end
    mode = 2'b01;
  endtask

  task automatic test_full_wrap();
    logic [4:0] r; logic ig, ij;
    logic exp_i [3] = '{1'b1, 1'b0, 1'b1};
    grant(A_INT, 1'b0);
    grant(A_NON, 1'b0);
    grant(A_INT, 1'b0);
    tests_run++;
    if (outstanding !== 2'd3 || proto_err !== 1'b0) begin
      tests_failed++; $display("FAIL full_fill out %0d perr %b exp 3 0", outstanding, proto_err);
    end
    grant(A_NON, 1'b0);
    tests_run++;
    if (proto_err !== 1'b1 || outstanding !== 2'd3) begin
      tests_failed++; $display("FAIL full_overflow perr %b out %0d exp 1 3", proto_err, outstanding);
    end
    tick();
    tests_run++;
    if (proto_err !== 1'b0) begin
      tests_failed++; $display("FAIL full_pulse perr %b exp 0", proto_err);
    end
    for (int i = 0; i < 3; i++) begin
      resp(32'h0, 1'b0, 5'b0, r, ig, ij);
      tests_run++;
      if (ig !== exp_i[i]) begin
        tests_failed++; $display("FAIL full_order[%0d] integ %b exp %b", i, ig, exp_i[i]);
      end
    end
    for (int i = 0; i < 7; i++) begin
      grant((i % 3 == 1) ? A_NON : A_INT, 1'b0);
      grant((i % 2 == 0) ? A_NON : A_INT, 1'b0);
      resp(32'h0, 1'b0, 5'b0, r, ig, ij);
      tests_run++;
      if (ig !== ((i % 3 == 1) ? 1'b0 : 1'b1)) begin
        tests_failed++; $display("FAIL wrap_a[%0d] integ %b", i, ig);
      end
      resp(32'h0, 1'b0, 5'b0, r, ig, ij);
      tests_run++;
      if (ig !== ((i % 2 == 0) ? 1'b0 : 1'b1)) begin
        tests_failed++; $display("FAIL wrap_b[%0d] integ %b", i, ig);
      end
    end
    tests_run++;
    if (outstanding !== 2'd0 || proto_err !== 1'b0) begin
      tests_failed++; $display("FAIL wrap_end out %0d perr %b exp 0 0", outstanding, proto_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] r; logic ig, ij;
    grant(A_INT, 1'b0);
    grant(A_NON, 1'b0);
    grant(A_INT, 1'b0);
    req = 1'b1; gnt = 1'b1; addr = A_NON; rvalid = 1'b1; rdata = 32'h0; err = 1'b0;
    #1;
    tests_run++;
    if (resp_integ !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_integ got %b exp 1", resp_integ);
    end
    tick();
    req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    tests_run++;
    if (outstanding !== 2'd3 || proto_err !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_full out %0d perr %b exp 3 0", outstanding, proto_err);
    end
    resp(32'h0, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ig !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_pop1 integ %b exp 0", ig);
    end
    resp(32'h0, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ig !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_pop2 integ %b exp 1", ig);
    end
    resp(32'h0, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ig !== 1'b0 || outstanding !== 2'd0) begin
      tests_failed++; $display("FAIL b2b_pop3 integ %b out %0d exp 0 0", ig, outstanding);
    end
  endtask

  task automatic test_pop_empty_reset();
    logic [4:0] r; logic ig, ij;
    resp(32'h0, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ig !== 1'b0 || proto_err !== 1'b1 || outstanding !== 2'd0) begin
      tests_failed++; $display("FAIL empty_pop integ %b perr %b out %0d exp 0 1 0", ig, proto_err, outstanding);
    end
    tick();
    tests_run++;
    if (proto_err !== 1'b0) begin
      tests_failed++; $display("FAIL empty_pulse perr %b exp 0", proto_err);
    end
    req = 1'b1; gnt = 1'b1; addr = A_INT; rvalid = 1'b1;
    tick();
    req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    tests_run++;
    if (proto_err !== 1'b1 || outstanding !== 2'd1) begin
      tests_failed++; $display("FAIL empty_pushpop perr %b out %0d exp 1 1", proto_err, outstanding);
    end
    grant(A_INT, 1'b0);
    tests_run++;
    if (outstanding !== 2'd2) begin
      tests_failed++; $display("FAIL pre_reset out %0d exp 2", outstanding);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (outstanding !== 2'd0) begin
      tests_failed++; $display("FAIL async_reset out %0d exp 0", outstanding);
    end
    tick();
    rst_n = 1'b1;
    tick();
    resp(32'h0, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ig !== 1'b0 || proto_err !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_pop integ %b perr %b exp 0 1", ig, proto_err);
    end
  endtask

  task automatic test_inject();
    logic [4:0] r, e; logic ig, ij, ex_inj, ev;
    mode = 2'b10; inj_period = 8'd3; inj_bit = 3'd4;
    for (int i = 1; i <= 9; i++) begin
      ev = (i == 9);
      grant(A_INT, 1'b0);
      resp(32'h0000_0001, ev, 5'b0, r, ig, ij);
      ex_inj = (i % 3 == 0);
      e = {ev, 4'b0001} ^ (ex_inj ? 5'b10000 : 5'b00000);
      tests_run++;
      if (ij !== ex_inj || r !== e) begin
        tests_failed++; $display("FAIL inject[%0d] inj %b rchk %b exp %b %b", i, ij, r, ex_inj, e);
      end
      grant(A_NON, 1'b0);
      resp(32'h0000_0001, 1'b0, 5'b0, r, ig, ij);
      tests_run++;
      if (ij !== 1'b0 || r !== 5'b11110) begin
        tests_failed++; $display("FAIL inject_nonint[%0d] inj %b rchk %b exp 0 11110", i, ij, r);
      end
    end
    inj_period = 8'd1; inj_bit = 3'd7;
    grant(A_INT, 1'b0);
    resp(32'h0000_0001, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ij !== 1'b1 || r !== 5'b00001) begin
      tests_failed++; $display("FAIL inject_bitrange inj %b rchk %b exp 1 00001", ij, r);
    end
    inj_period = 8'd0; inj_bit = 3'd0;
    grant(A_INT, 1'b0);
    resp(32'h0000_0001, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ij !== 1'b0 || r !== 5'b00001) begin
      tests_failed++; $display("FAIL inject_period0 inj %b rchk %b exp 0 00001", ij, r);
    end
    inj_period = 8'd5;
    for (int i = 0; i < 3; i++) begin
      grant(A_INT, 1'b0);
      resp(32'h0000_0001, 1'b0, 5'b0, r, ig, ij);
      tests_run++;
      if (ij !== 1'b0) begin
        tests_failed++; $display("FAIL inject_p5[%0d] inj %b exp 0", i, ij);
      end
    end
    inj_period = 8'd2;
    grant(A_INT, 1'b0);
    resp(32'h0000_0001, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ij !== 1'b1 || r !== 5'b00000) begin
      tests_failed++; $display("FAIL inject_lowered inj %b rchk %b exp 1 00000", ij, r);
    end
    mode = 2'b01; inj_period = 8'd0;
  endtask

  task automatic test_dbg();
    logic [4:0] r; logic ig, ij;
    grant(32'hF000_0800, 1'b1);
    resp(32'h0, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ig !== 1'b0) begin
      tests_failed++; $display("FAIL dbg_dm integ %b exp 0", ig);
    end
    grant(32'hF000_0800, 1'b0);
    resp(32'h0, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ig !== 1'b1) begin
      tests_failed++; $display("FAIL nodbg_dm integ %b exp 1", ig);
    end
    grant(A_INT, 1'b1);
    resp(32'h0, 1'b0, 5'b0, r, ig, ij);
    tests_run++;
    if (ig !== 1'b1) begin
      tests_failed++; $display("FAIL dbg_outside integ %b exp 1", ig);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; gnt = 1'b0; dbg = 1'b0; addr = '0; rdata = '0;
    rvalid = 1'b0; err = 1'b0; rchk_in = '0; mode = 2'b01; inj_period = 8'd0; inj_bit = '0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_gen_pass();
    test_full_wrap();
    test_back_to_back();
    test_pop_empty_reset();
    test_inject();
    test_dbg();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
